// File: rtl/wsacc_pe_cluster_db_if.sv
// rtl/wsacc_pe_cluster_db_if.sv - activation, weight and result handshake bundle for the PE cluster
interface wsacc_pe_cluster_db_if #(
   parameter int numPes               = 32,
   parameter int windowElements       = 9,
   parameter int dataWidth            = 8,
   parameter int outputWidth          = 16,
   parameter int weightInterfaceWidth = 32
);
   logic [numPes*windowElements*dataWidth-1:0] data_i;
   logic                                       data_i_valid;
   logic                                       data_i_ready;
   logic [weightInterfaceWidth-1:0]            weight_itf_i;
   logic                                       weight_itf_i_valid;
   logic                                       weight_itf_i_ready;
   logic                                       weight_swap_i;
   logic                                       weight_shadow_full_o;
   logic                                       active_bank_o;
   logic [numPes*outputWidth-1:0]              data_o;
   logic                                       data_o_valid;
   logic                                       data_o_ready;

   modport slave (
      input  data_i, data_i_valid, weight_itf_i, weight_itf_i_valid, weight_swap_i, data_o_ready,
      output data_i_ready, weight_itf_i_ready, weight_shadow_full_o, active_bank_o, data_o, data_o_valid
   );

   modport master (
      output data_i, data_i_valid, weight_itf_i, weight_itf_i_valid, weight_swap_i, data_o_ready,
      input  data_i_ready, weight_itf_i_ready, weight_shadow_full_o, active_bank_o, data_o, data_o_valid
   );
endinterface

// File: rtl/wsacc_pe_cluster_db.sv
// rtl/wsacc_pe_cluster_db.sv - weight-stationary PE cluster with ping-pong weight banks
module wsacc_pe_cluster_db #(
   parameter int numPes               = 32,
   parameter int windowElements       = 9,
   parameter int dataWidth            = 8,
   parameter int outputWidth          = 16,
   parameter int weightInterfaceWidth = 32,
   parameter int SATURATE             = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   wsacc_pe_cluster_db_if.slave bus
);
   localparam int lanes        = (weightInterfaceWidth / dataWidth > 0) ? weightInterfaceWidth / dataWidth : 1;
   localparam int numWriteSets = (numPes + lanes - 1) / lanes;
   localparam int accWidth     = 2 * dataWidth + $clog2(windowElements);
   localparam int extWidth     = (accWidth > outputWidth) ? accWidth : outputWidth;
   localparam int setW         = (numWriteSets > 1) ? $clog2(numWriteSets) : 1;
   localparam int tapW         = (windowElements > 1) ? $clog2(windowElements) : 1;

   localparam logic signed [extWidth-1:0] sat_max = {{(extWidth-outputWidth+1){1'b0}}, {(outputWidth-1){1'b1}}};
   localparam logic signed [extWidth-1:0] sat_min = {{(extWidth-outputWidth+1){1'b1}}, {(outputWidth-1){1'b0}}};

   typedef enum logic {LOADING, FULL} load_state_t;

   load_state_t                   state;
   logic [setW-1:0]               set_cnt;
   logic [tapW-1:0]               tap_cnt;
   logic                          active_bank;
   logic                          weights_valid;
   logic                          shadow_full;
   logic                          weight_ready;
   logic signed [dataWidth-1:0]   bank [2][numPes][windowElements];
   logic [numPes*outputWidth-1:0] data_q;
   logic [numPes*outputWidth-1:0] data_next;
   logic                          data_valid_q;
   logic                          accept;

   assign bus.weight_itf_i_ready   = weight_ready;
   assign bus.weight_shadow_full_o = shadow_full;
   assign bus.active_bank_o        = active_bank;
   assign bus.data_o               = data_q;
   assign bus.data_o_valid         = data_valid_q;
   assign bus.data_i_ready         = weights_valid & (~data_valid_q | bus.data_o_ready);
   assign accept                   = bus.data_i_valid & bus.data_i_ready;

   // Loads always target the bank not in use; a swap is only honoured once that bank is complete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= LOADING;
         set_cnt       <= '0;
         tap_cnt       <= '0;
         active_bank   <= 1'b0;
         weights_valid <= 1'b0;
         shadow_full   <= 1'b0;
         weight_ready  <= 1'b1;
         for (int b = 0; b < 2; b++)
            for (int p = 0; p < numPes; p++)
               for (int t = 0; t < windowElements; t++)
                  bank[b][p][t] <= '0;
      end else begin
         case (state)
            LOADING: begin
               if (bus.weight_itf_i_valid && weight_ready) begin
                  for (int k = 0; k < lanes; k++)
                     if (int'(set_cnt) * lanes + k < numPes)
                        bank[~active_bank][int'(set_cnt) * lanes + k][tap_cnt] <=
                           bus.weight_itf_i[k*dataWidth +: dataWidth];
                  if (set_cnt == setW'(numWriteSets - 1)) begin
                     set_cnt <= '0;
                     if (tap_cnt == tapW'(windowElements - 1)) begin
                        tap_cnt      <= '0;
                        state        <= FULL;
                        shadow_full  <= 1'b1;
                        weight_ready <= 1'b0;
                     end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                     end
                  end else begin
                     set_cnt <= set_cnt + 1'b1;
                  end
               end
            end
            FULL: begin
               if (bus.weight_swap_i) begin
                  active_bank   <= ~active_bank;
                  weights_valid <= 1'b1;
                  state         <= LOADING;
                  shadow_full   <= 1'b0;
                  weight_ready  <= 1'b1;
               end
            end
            default: state <= LOADING;
         endcase
      end
   end

   always_comb begin
      logic signed [2*dataWidth-1:0] prod;
      logic signed [accWidth-1:0]    acc;
      logic signed [extWidth-1:0]    acc_ext;
      prod      = '0;
      acc       = '0;
      acc_ext   = '0;
      data_next = '0;
      for (int p = 0; p < numPes; p++) begin
         acc = '0;
         for (int t = 0; t < windowElements; t++) begin
            prod = $signed(bus.data_i[(p*windowElements+t)*dataWidth +: dataWidth]) * bank[active_bank][p][t];
            acc  = acc + accWidth'(prod);
         end
         acc_ext = extWidth'(acc);
         if (SATURATE != 0 && acc_ext > sat_max)
            data_next[p*outputWidth +: outputWidth] = sat_max[outputWidth-1:0];
         else if (SATURATE != 0 && acc_ext < sat_min)
            data_next[p*outputWidth +: outputWidth] = sat_min[outputWidth-1:0];
         else
            data_next[p*outputWidth +: outputWidth] = acc_ext[outputWidth-1:0];
      end
   end

   // Output holds while downstream stalls; input is only accepted when this slot can drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q       <= '0;
         data_valid_q <= 1'b0;
      end else if (accept) begin
         data_q       <= data_next;
         data_valid_q <= 1'b1;
      end else if (bus.data_o_ready) begin
         data_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wsacc_pe_cluster_db.sv
// tb/tb_wsacc_pe_cluster_db.sv - directed bench for wsacc_pe_cluster_db (saturating and wrapping)
module tb_wsacc_pe_cluster_db;
   localparam int NP = 32, WE = 9, DW = 8, OW = 16, WIW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wsacc_pe_cluster_db_if #(.numPes(NP), .windowElements(WE), .dataWidth(DW), .outputWidth(OW),
                            .weightInterfaceWidth(WIW)) bus0 ();
   wsacc_pe_cluster_db_if #(.numPes(NP), .windowElements(WE), .dataWidth(DW), .outputWidth(OW),
                            .weightInterfaceWidth(WIW)) bus1 ();

   // The wrapping instance sees exactly the same stimulus as the saturating one.
   assign bus1.data_i             = bus0.data_i;
   assign bus1.data_i_valid       = bus0.data_i_valid;
   assign bus1.weight_itf_i       = bus0.weight_itf_i;
   assign bus1.weight_itf_i_valid = bus0.weight_itf_i_valid;
   assign bus1.weight_swap_i      = bus0.weight_swap_i;
   assign bus1.data_o_ready       = bus0.data_o_ready;

   wsacc_pe_cluster_db #(.numPes(NP), .windowElements(WE), .dataWidth(DW), .outputWidth(OW),
                         .weightInterfaceWidth(WIW), .SATURATE(1)) u_sat (.clk(clk), .rst(rst), .bus(bus0));
   wsacc_pe_cluster_db #(.numPes(NP), .windowElements(WE), .dataWidth(DW), .outputWidth(OW),
                         .weightInterfaceWidth(WIW), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(bus1));

   function automatic bit all_pe(input logic [NP*OW-1:0] d, input logic [OW-1:0] e);
      for (int i = 0; i < NP; i++)
         if (d[i*OW +: OW] !== e) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send_word(input logic [WIW-1:0] w);
      int n = 0;
      bus0.weight_itf_i       = w;
      bus0.weight_itf_i_valid = 1'b1;
      while (bus0.weight_itf_i_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL word_timeout ready=%b required=1", bus0.weight_itf_i_ready);
      end
      @(negedge clk);
      bus0.weight_itf_i_valid = 1'b0;
   endtask

   task automatic load_bank(input logic [DW-1:0] w, input int n);
      for (int i = 0; i < n; i++) send_word({4{w}});
   endtask

   task automatic do_swap();
      bus0.weight_swap_i = 1'b1;
      @(negedge clk);
      bus0.weight_swap_i = 1'b0;
   endtask

   task automatic set_data(input logic [DW-1:0] v);
      bus0.data_i = {(NP*WE){v}};
   endtask

   task automatic beat(input logic [DW-1:0] v);
      set_data(v);
      checks++;
      if (bus0.data_i_ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_ready got=%b required=1", bus0.data_i_ready);
      end
      bus0.data_i_valid = 1'b1;
      @(negedge clk);
      bus0.data_i_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks += 6;
      if (bus0.active_bank_o !== 1'b0) begin errors++; $display("FAIL rst_active got=%b required=0", bus0.active_bank_o); end
      if (bus0.weight_shadow_full_o !== 1'b0) begin errors++; $display("FAIL rst_full got=%b required=0", bus0.weight_shadow_full_o); end
      if (bus0.weight_itf_i_ready !== 1'b1) begin errors++; $display("FAIL rst_wready got=%b required=1", bus0.weight_itf_i_ready); end
      if (bus0.data_i_ready !== 1'b0) begin errors++; $display("FAIL rst_dready got=%b required=0", bus0.data_i_ready); end
      if (bus0.data_o_valid !== 1'b0) begin errors++; $display("FAIL rst_dvalid got=%b required=0", bus0.data_o_valid); end
      if (bus0.data_o !== '0) begin errors++; $display("FAIL rst_data got=%h required=0", bus0.data_o[15:0]); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load();
      load_bank(8'd1, 71);
      checks += 2;
      if (bus0.weight_shadow_full_o !== 1'b0) begin errors++; $display("FAIL load71_full got=%b required=0", bus0.weight_shadow_full_o); end
      if (bus0.weight_itf_i_ready !== 1'b1) begin errors++; $display("FAIL load71_wready got=%b required=1", bus0.weight_itf_i_ready); end
      load_bank(8'd1, 1);
      checks += 2;
      if (bus0.weight_shadow_full_o !== 1'b1) begin errors++; $display("FAIL load72_full got=%b required=1", bus0.weight_shadow_full_o); end
      if (bus0.weight_itf_i_ready !== 1'b0) begin errors++; $display("FAIL load72_wready got=%b required=0", bus0.weight_itf_i_ready); end
      bus0.weight_itf_i_valid = 1'b1;
      @(negedge clk);
      bus0.weight_itf_i_valid = 1'b0;
      checks += 3;
      if (bus0.weight_itf_i_ready !== 1'b0) begin errors++; $display("FAIL word73_stall got=%b required=0", bus0.weight_itf_i_ready); end
      if (bus0.weight_shadow_full_o !== 1'b1) begin errors++; $display("FAIL word73_full got=%b required=1", bus0.weight_shadow_full_o); end
      if (bus0.data_i_ready !== 1'b0) begin errors++; $display("FAIL preswap_dready got=%b required=0", bus0.data_i_ready); end
      do_swap();
      checks += 4;
      if (bus0.active_bank_o !== 1'b1) begin errors++; $display("FAIL swap_active got=%b required=1", bus0.active_bank_o); end
      if (bus0.weight_itf_i_ready !== 1'b1) begin errors++; $display("FAIL swap_wready got=%b required=1", bus0.weight_itf_i_ready); end
      if (bus0.weight_shadow_full_o !== 1'b0) begin errors++; $display("FAIL swap_full got=%b required=0", bus0.weight_shadow_full_o); end
      if (bus0.data_i_ready !== 1'b1) begin errors++; $display("FAIL swap_dready got=%b required=1", bus0.data_i_ready); end
   endtask

   task automatic test_compute();
      bus0.data_o_ready = 1'b1;
      beat(8'd2);
      checks += 3;
      if (bus0.data_o_valid !== 1'b1) begin errors++; $display("FAIL compute_valid got=%b required=1", bus0.data_o_valid); end
      if (!all_pe(bus0.data_o, 16'd18)) begin errors++; $display("FAIL compute_data pe0=%0d required=18", bus0.data_o[15:0]); end
      if (!all_pe(bus1.data_o, 16'd18)) begin errors++; $display("FAIL compute_wrap pe0=%0d required=18", bus1.data_o[15:0]); end
      @(negedge clk);
      checks++;
      if (bus0.data_o_valid !== 1'b0) begin errors++; $display("FAIL compute_drain got=%b required=0", bus0.data_o_valid); end
   endtask

   task automatic test_ping_pong();
      int bad = 0;
      set_data(8'd2);
      bus0.data_i_valid       = 1'b1;
      bus0.weight_itf_i       = {4{8'd2}};
      bus0.weight_itf_i_valid = 1'b1;
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         if (bus0.data_o_valid !== 1'b1 || !all_pe(bus0.data_o, 16'd18)) bad++;
      end
      bus0.weight_itf_i_valid = 1'b0;
      checks += 2;
      if (bad != 0) begin errors++; $display("FAIL pingpong_stream bad_beats=%0d required=0", bad); end
      if (bus0.weight_shadow_full_o !== 1'b1) begin errors++; $display("FAIL pingpong_full got=%b required=1", bus0.weight_shadow_full_o); end
      do_swap();
      checks += 2;
      if (!all_pe(bus0.data_o, 16'd18)) begin errors++; $display("FAIL pingpong_old pe0=%0d required=18", bus0.data_o[15:0]); end
      if (bus0.active_bank_o !== 1'b0) begin errors++; $display("FAIL pingpong_active got=%b required=0", bus0.active_bank_o); end
      @(negedge clk);
      bus0.data_i_valid = 1'b0;
      checks++;
      if (!all_pe(bus0.data_o, 16'd36)) begin errors++; $display("FAIL pingpong_new pe0=%0d required=36", bus0.data_o[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      load_bank(8'd127, 72);
      do_swap();
      beat(8'd127);
      checks += 2;
      if (!all_pe(bus0.data_o, 16'h7fff)) begin errors++; $display("FAIL sat_pos pe0=%h required=7fff", bus0.data_o[15:0]); end
      if (!all_pe(bus1.data_o, 16'h3709)) begin errors++; $display("FAIL wrap_pos pe0=%h required=3709", bus1.data_o[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_negative();
      load_bank(8'h80, 72);
      do_swap();
      beat(8'd127);
      checks += 2;
      if (!all_pe(bus0.data_o, 16'h8000)) begin errors++; $display("FAIL sat_neg pe0=%h required=8000", bus0.data_o[15:0]); end
      if (!all_pe(bus1.data_o, 16'hc480)) begin errors++; $display("FAIL wrap_neg pe0=%h required=c480", bus1.data_o[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      set_data(8'd1);
      bus0.data_i_valid = 1'b1;
      @(negedge clk);
      set_data(8'd2);
      checks += 2;
      if (!all_pe(bus0.data_o, 16'hfb80)) begin errors++; $display("FAIL b2b_1 pe0=%h required=fb80", bus0.data_o[15:0]); end
      if (bus0.data_i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b required=1", bus0.data_i_ready); end
      @(negedge clk);
      set_data(8'd3);
      checks++;
      if (!all_pe(bus0.data_o, 16'hf700)) begin errors++; $display("FAIL b2b_2 pe0=%h required=f700", bus0.data_o[15:0]); end
      @(negedge clk);
      bus0.data_i_valid = 1'b0;
      checks++;
      if (!all_pe(bus0.data_o, 16'hf280)) begin errors++; $display("FAIL b2b_3 pe0=%h required=f280", bus0.data_o[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad = 0;
      bus0.data_o_ready = 1'b0;
      set_data(8'd1);
      bus0.data_i_valid = 1'b1;
      @(negedge clk);
      set_data(8'd0);
      for (int i = 0; i < 5; i++) begin
         if (bus0.data_i_ready !== 1'b0 || bus0.data_o_valid !== 1'b1 || !all_pe(bus0.data_o, 16'hfb80)) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d required=0", bad); end
      bus0.data_o_ready = 1'b1;
      @(negedge clk);
      bus0.data_i_valid = 1'b0;
      checks += 2;
      if (bus0.data_o_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid got=%b required=1", bus0.data_o_valid); end
      if (!all_pe(bus0.data_o, 16'h0000)) begin errors++; $display("FAIL stall_release_data pe0=%h required=0", bus0.data_o[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      load_bank(8'd3, 72);
      do_swap();
      beat(8'd1);
      checks++;
      if (!all_pe(bus0.data_o, 16'd27)) begin errors++; $display("FAIL pre_rst_data pe0=%0d required=27", bus0.data_o[15:0]); end
      load_bank(8'd1, 10);
      rst = 1'b1;
      #1;
      checks += 6;
      if (bus0.active_bank_o !== 1'b0) begin errors++; $display("FAIL mid_rst_active got=%b required=0", bus0.active_bank_o); end
      if (bus0.weight_shadow_full_o !== 1'b0) begin errors++; $display("FAIL mid_rst_full got=%b required=0", bus0.weight_shadow_full_o); end
      if (bus0.weight_itf_i_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_wready got=%b required=1", bus0.weight_itf_i_ready); end
      if (bus0.data_i_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_dready got=%b required=0", bus0.data_i_ready); end
      if (bus0.data_o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dvalid got=%b required=0", bus0.data_o_valid); end
      if (bus0.data_o !== '0) begin errors++; $display("FAIL mid_rst_data got=%h required=0", bus0.data_o[15:0]); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_swap();
      checks += 2;
      if (bus0.active_bank_o !== 1'b0) begin errors++; $display("FAIL early_swap_active got=%b required=0", bus0.active_bank_o); end
      if (bus0.data_i_ready !== 1'b0) begin errors++; $display("FAIL early_swap_dready got=%b required=0", bus0.data_i_ready); end
      load_bank(8'd1, 71);
      do_swap();
      checks++;
      if (bus0.active_bank_o !== 1'b0) begin errors++; $display("FAIL partial_swap_active got=%b required=0", bus0.active_bank_o); end
      load_bank(8'd1, 1);
      checks++;
      if (bus0.weight_shadow_full_o !== 1'b1) begin errors++; $display("FAIL reload_full got=%b required=1", bus0.weight_shadow_full_o); end
      do_swap();
      checks++;
      if (bus0.active_bank_o !== 1'b1) begin errors++; $display("FAIL reload_active got=%b required=1", bus0.active_bank_o); end
      beat(8'd2);
      checks++;
      if (!all_pe(bus0.data_o, 16'd18)) begin errors++; $display("FAIL reload_data pe0=%0d required=18", bus0.data_o[15:0]); end
      @(negedge clk);
   endtask

   initial begin
      bus0.data_i             = '0;
      bus0.data_i_valid       = 1'b0;
      bus0.weight_itf_i       = '0;
      bus0.weight_itf_i_valid = 1'b0;
      bus0.weight_swap_i      = 1'b0;
      bus0.data_o_ready       = 1'b0;
      test_reset();
      test_load();
      test_compute();
      test_ping_pong();
      test_saturation();
      test_negative();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
